// File: rtl/snow64_long_div_udiv.sv
// snow64_long_div_udiv: iterative unsigned radix-2^LOG2_RADIX long divider.
// Returns quotient and remainder and flags division by zero. Uses the
// start / can-accept / data-valid handshake of the other long-latency units.
// Optional macro SNOW64_LONG_DIV_UDIV_EARLY_OUT_EN: commands whose divisor is
// zero or exceeds the dividend complete after one working cycle.
module snow64_long_div_udiv #(
  parameter int unsigned WIDTH_A    = 16,
  parameter int unsigned WIDTH_B    = 8,
  parameter int unsigned LOG2_RADIX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_start,
  input  logic [WIDTH_A-1:0] in_a,
  input  logic [WIDTH_B-1:0] in_b,
  output logic               out_can_accept_cmd,
  output logic               out_data_valid,
  output logic [WIDTH_A-1:0] out_quot,
  output logic [WIDTH_B-1:0] out_rem,
  output logic               out_div_by_zero
);

  localparam int unsigned ITERS = (WIDTH_A + LOG2_RADIX - 1) / LOG2_RADIX;
  localparam int unsigned EXT_W = ITERS * LOG2_RADIX;
  localparam int unsigned RADIX = 1 << LOG2_RADIX;
  localparam int unsigned MW    = WIDTH_B + LOG2_RADIX;
  localparam int unsigned CW    = $clog2(ITERS + 1);

  typedef enum logic {StIdle, StWorking} state_t;

  state_t              state_q;
  logic [EXT_W-1:0]    a_q;
  logic [EXT_W-1:0]    quot_acc_q;
  logic [WIDTH_B-1:0]  prem_q;
  logic [MW-1:0]       mult_q [RADIX];
  logic [CW-1:0]       cnt_q;
  logic                dbz_q;
  logic                early_q;

  logic                can_accept_q;
  logic                data_valid_q;
  logic [WIDTH_A-1:0]  quot_q;
  logic [WIDTH_B-1:0]  rem_q;
  logic                div_by_zero_q;

  logic                b_zero;
  logic [EXT_W-1:0]    a_ext_d;
  logic [WIDTH_B-1:0]  b_eff_d;
  logic [MW-1:0]       mult_d [RADIX];
  logic                early_d;

  logic [MW-1:0]         cur;
  logic [LOG2_RADIX-1:0] digit;
  logic [LOG2_RADIX-1:0] trial;
  logic [WIDTH_B-1:0]    prem_d;
  logic [EXT_W-1:0]      quot_d;

  assign out_can_accept_cmd = can_accept_q;
  assign out_data_valid     = data_valid_q;
  assign out_quot           = quot_q;
  assign out_rem            = rem_q;
  assign out_div_by_zero    = div_by_zero_q;

  // Command capture: sanitise a zero divisor and precompute the divisor multiples.
  always_comb begin
    b_zero  = (in_b == '0);
    a_ext_d = b_zero ? '0 : EXT_W'(in_a);
    b_eff_d = b_zero ? WIDTH_B'(1) : in_b;
    for (int unsigned k = 0; k < RADIX; k++) begin
      mult_d[k] = MW'(k) * MW'(b_eff_d);
    end
`ifdef SNOW64_LONG_DIV_UDIV_EARLY_OUT_EN
    early_d = b_zero || (in_a < WIDTH_A'(in_b));
`else
    early_d = 1'b0;
`endif
  end

  // One quotient digit per cycle: binary search over the monotonic multiples.
  always_comb begin
    cur   = {prem_q, a_q[EXT_W-1 -: LOG2_RADIX]};
    digit = '0;
    trial = '0;
    for (int unsigned j = LOG2_RADIX; j > 0; j--) begin
      trial = digit | LOG2_RADIX'(1 << (j - 1));
      if (mult_q[trial] <= cur) digit = trial;
    end
    prem_d = WIDTH_B'(cur - mult_q[digit]);
    // Shifting digits in from the LSB places each at counter*LOG2_RADIX.
    quot_d = (quot_acc_q << LOG2_RADIX) | EXT_W'(digit);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      a_q           <= '0;
      quot_acc_q    <= '0;
      prem_q        <= '0;
      cnt_q         <= '0;
      dbz_q         <= 1'b0;
      early_q       <= 1'b0;
      for (int unsigned k = 0; k < RADIX; k++) mult_q[k] <= '0;
      can_accept_q  <= 1'b1;
      data_valid_q  <= 1'b0;
      quot_q        <= '0;
      rem_q         <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_start) begin
            a_q          <= a_ext_d;
            mult_q       <= mult_d;
            prem_q       <= '0;
            quot_acc_q   <= '0;
            cnt_q        <= early_d ? '0 : CW'(ITERS - 1);
            dbz_q        <= b_zero;
            early_q      <= early_d;
            data_valid_q <= 1'b0;
            can_accept_q <= 1'b0;
            state_q      <= StWorking;
          end
        end
        StWorking: begin
          a_q        <= a_q << LOG2_RADIX;
          prem_q     <= prem_d;
          quot_acc_q <= quot_d;
          cnt_q      <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            // Early-out leaves a_q unshifted, so it still holds the remainder.
            if (early_q) begin
              quot_q <= '0;
              rem_q  <= a_q[WIDTH_B-1:0];
            end else begin
              quot_q <= WIDTH_A'(quot_d);
              rem_q  <= prem_d;
            end
            div_by_zero_q <= dbz_q;
            data_valid_q  <= 1'b1;
            can_accept_q  <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
